// File: rtl/nn_pkg.sv
// Shared constants and loader state encoding for the feed-forward core
// and its weight loader.
package nn_pkg;

   localparam int WWIDTH = 8;
   localparam int WORD_W = 256;
   localparam int DEPTH  = 4;
   localparam int AW     = 4;
   localparam int BPW    = WORD_W / WWIDTH;

   typedef enum logic [1:0] {
      IDLE,
      COLLECT,
      WRITE,
      DONE
   } ld_state_e;

endpackage

// File: rtl/nn_word_packer.sv
// Packs weights into a RAM word, lowest weight at the lowest bits.
// State moves on the falling clock edge.
module nn_word_packer #(
   parameter int WWIDTH = 8,
   parameter int WORD_W = 256
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              wr,
   input  logic [WWIDTH-1:0] din,
   output logic [WORD_W-1:0] word,
   output logic              last
);

   localparam int BPW = WORD_W / WWIDTH;
   localparam int BCW = $clog2(BPW);

   logic [BCW-1:0] byte_cnt;

   assign last = (byte_cnt == BCW'(BPW - 1));

   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word     <= '0;
         byte_cnt <= '0;
      end else if (clr) begin
         word     <= '0;
         byte_cnt <= '0;
      end else if (wr) begin
         word[byte_cnt*WWIDTH +: WWIDTH] <= din;
         byte_cnt <= last ? '0 : byte_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/nn_weight_loader.sv
// Streams weights into the weight RAM one packed word at a time.
// Updates on the falling edge so RAM inputs settle before its rising edge.
module nn_weight_loader #(
   parameter int WWIDTH = 8,
   parameter int WORD_W = 256,
   parameter int DEPTH  = 4,
   parameter int AW     = 4
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              start,
   input  logic [WWIDTH-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [AW-1:0]     mem_addr,
   output logic [WORD_W-1:0] mem_wdata,
   output logic              mem_we,
   output logic              busy,
   output logic              done
);

   import nn_pkg::*;

   ld_state_e     state;
   ld_state_e     state_nxt;
   logic [AW-1:0] addr_cnt;
   logic          clr;
   logic          wr;
   logic          inc;
   logic          last;

   nn_word_packer #(
      .WWIDTH (WWIDTH),
      .WORD_W (WORD_W)
   ) u_packer (
      .clk   (CLK),
      .rst_n (RST),
      .clr   (clr),
      .wr    (wr),
      .din   (in_data),
      .word  (mem_wdata),
      .last  (last)
   );

   assign mem_addr = addr_cnt;

   always_ff @(negedge CLK or negedge RST) begin
      if (!RST) begin
         state    <= IDLE;
         addr_cnt <= '0;
      end else begin
         state <= state_nxt;
         if (clr)
            addr_cnt <= '0;
         else if (inc)
            addr_cnt <= addr_cnt + 1'b1;
      end
   end

   // Outputs decode from state only, so reset clears them at once.
   always_comb begin
      state_nxt = state;
      clr       = 1'b0;
      wr        = 1'b0;
      inc       = 1'b0;
      in_ready  = 1'b0;
      mem_we    = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               clr       = 1'b1;
               state_nxt = COLLECT;
            end
         end
         COLLECT: begin
            in_ready = 1'b1;
            busy     = 1'b1;
            wr       = in_valid;
            if (in_valid && last)
               state_nxt = WRITE;
         end
         WRITE: begin
            mem_we = 1'b1;
            busy   = 1'b1;
            if (addr_cnt == AW'(DEPTH - 1)) begin
               state_nxt = DONE;
            end else begin
               inc       = 1'b1;
               state_nxt = COLLECT;
            end
         end
         DONE: begin
            done = 1'b1;
            if (start) begin
               clr       = 1'b1;
               state_nxt = COLLECT;
            end
         end
      endcase
   end

endmodule
